seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx_if.sv | 33 +++
 rtl/seq_pattern_tx.sv | 134 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Bundle between the pattern transmitter and whatever drives or consumes it.
// Configuration, control and the serial handshake travel together here.
interface seq_pattern_tx_if;
    logic        load;
    logic [15:0] pattern;
    logic [3:0]  length;
    logic [3:0]  repeats;
    logic [3:0]  gap;
    logic        start;
    logic        abort;
    logic        ready;
    logic        x_out;
    logic        x_valid;
    logic        busy;
    logic        done;
    logic [3:0]  bit_idx;
    logic [3:0]  rep_idx;
    logic [7:0]  tx_count;

    modport master (
        output load, pattern, length, repeats, gap,
        output start, abort, ready,
        input  x_out, x_valid, busy, done,
        input  bit_idx, rep_idx, tx_count
    );

    modport slave (
        input  load, pattern, length, repeats, gap,
        input  start, abort, ready,
        output x_out, x_valid, busy, done,
        output bit_idx, rep_idx, tx_count
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a loaded bit pattern MSB-first in
// repeated bursts with optional idle gaps, under a valid/ready handshake.
module seq_pattern_tx (
    input  logic          clk,
    input  logic          rst,
    seq_pattern_tx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] pattern_r;
    logic [3:0]  length_r;
    logic [3:0]  repeats_r;
    logic [3:0]  gap_r;
    logic [3:0]  gap_cnt;

    logic        x_out_r;
    logic        x_valid_r;
    logic        busy_r;
    logic        done_r;
    logic [3:0]  bit_idx_r;
    logic [3:0]  rep_idx_r;
    logic [7:0]  tx_count_r;

    // Start uses freshly loaded values when load and start coincide.
    logic [15:0] pat_sel;
    logic [3:0]  len_sel;

    assign pat_sel = bus.load ? bus.pattern : pattern_r;
    assign len_sel = bus.load ? bus.length  : length_r;

    assign bus.x_out    = x_out_r;
    assign bus.x_valid  = x_valid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.bit_idx  = bit_idx_r;
    assign bus.rep_idx  = rep_idx_r;
    assign bus.tx_count = tx_count_r;

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pattern_r  <= '0;
            length_r   <= '0;
            repeats_r  <= '0;
            gap_r      <= '0;
            gap_cnt    <= '0;
            x_out_r    <= 1'b0;
            x_valid_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bit_idx_r  <= '0;
            rep_idx_r  <= '0;
            tx_count_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.load) begin
                        pattern_r <= bus.pattern;
                        length_r  <= bus.length;
                        repeats_r <= bus.repeats;
                        gap_r     <= bus.gap;
                    end
                    if (bus.start) begin
                        state     <= SEND;
                        bit_idx_r <= len_sel;
                        rep_idx_r <= '0;
                        x_out_r   <= pat_sel[len_sel];
                        x_valid_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        x_out_r   <= 1'b0;
                        x_valid_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else if (x_valid_r && bus.ready) begin
                        tx_count_r <= tx_count_r + 8'd1;
                        if (bit_idx_r != 4'd0) begin
                            bit_idx_r <= bit_idx_r - 4'd1;
                            x_out_r   <= pattern_r[bit_idx_r - 4'd1];
                        end else if (rep_idx_r == repeats_r) begin
                            state     <= DONE;
                            x_out_r   <= 1'b0;
                            x_valid_r <= 1'b0;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end else if (gap_r == 4'd0) begin
                            bit_idx_r <= length_r;
                            rep_idx_r <= rep_idx_r + 4'd1;
                            x_out_r   <= pattern_r[length_r];
                        end else begin
                            state     <= GAP;
                            gap_cnt   <= gap_r;
                            x_out_r   <= 1'b0;
                            x_valid_r <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        x_out_r   <= 1'b0;
                        x_valid_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else if (gap_cnt <= 4'd1) begin
                        state     <= SEND;
                        bit_idx_r <= length_r;
                        rep_idx_r <= rep_idx_r + 4'd1;
                        x_out_r   <= pattern_r[length_r];
                        x_valid_r <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a queue-of-slots reference:
// each start expands into the list of bits, gap cycles and a done pulse.
module tb_seq_pattern_tx;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_pattern_tx_if bus ();

    seq_pattern_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // kind: 0 = data bit, 1 = gap cycle, 2 = done pulse
    typedef struct {
        int kind;
        int b;
        int idx;
        int rep;
    } slot_t;

    slot_t       q[$];
    logic [15:0] sp;
    int          sl, sr, sg;
    int          m_tx;
    int          last_i, last_r;
    int          n_chk = 0;
    int          n_pass = 0;
    int          hold;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_outs();
        int ev, ex, eb, ed, ei, er;
        ev = 0; ex = 0; eb = 0; ed = 0;
        ei = last_i; er = last_r;
        if (q.size() != 0) begin
            ei = q[0].idx;
            er = q[0].rep;
            case (q[0].kind)
                0: begin ev = 1; ex = q[0].b; eb = 1; end
                1: begin eb = 1; end
                default: begin ed = 1; end
            endcase
        end
        chk("x_valid", int'(bus.x_valid), ev);
        chk("x_out", int'(bus.x_out), ex);
        chk("busy", int'(bus.busy), eb);
        chk("done", int'(bus.done), ed);
        chk("bit_idx", int'(bus.bit_idx), ei);
        chk("rep_idx", int'(bus.rep_idx), er);
        chk("tx_count", int'(bus.tx_count), m_tx);
    endtask

    task automatic build();
        for (int r = 0; r <= sr; r++) begin
            for (int i = sl; i >= 0; i--)
                q.push_back('{0, int'(sp[i]), i, r});
            if (r < sr)
                for (int g = 0; g < sg; g++)
                    q.push_back('{1, 0, 0, r});
        end
        q.push_back('{2, 0, 0, sr});
    endtask

    task automatic pop();
        last_i = q[0].idx;
        last_r = q[0].rep;
        void'(q.pop_front());
    endtask

    task automatic model_edge();
        if (rst) begin
            q.delete();
            sp = '0; sl = 0; sr = 0; sg = 0;
            m_tx = 0; last_i = 0; last_r = 0;
        end else if (q.size() == 0) begin
            if (bus.load) begin
                sp = bus.pattern;
                sl = int'(bus.length);
                sr = int'(bus.repeats);
                sg = int'(bus.gap);
            end
            if (bus.start) build();
        end else if (q[0].kind != 2 && bus.abort) begin
            last_i = q[0].idx;
            last_r = q[0].rep;
            q.delete();
        end else if (q[0].kind == 0) begin
            if (bus.ready) begin
                m_tx = (m_tx + 1) % 256;
                pop();
            end
        end else begin
            pop();
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [15:0] p, input int l,
                       input int r, input int g, input logic st);
        bus.load    = 1'b1;
        bus.start   = st;
        bus.pattern = p;
        bus.length  = 4'(l);
        bus.repeats = 4'(r);
        bus.gap     = 4'(g);
        step();
        bus.load  = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin
            step();
            n++;
        end
        if (q.size() != 0) chk("timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.load    = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.ready   = 1'b1;
        bus.pattern = '0;
        bus.length  = '0;
        bus.repeats = '0;
        bus.gap     = '0;
        sp = '0; sl = 0; sr = 0; sg = 0;
        m_tx = 0; last_i = 0; last_r = 0;
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        step();

        // Three ones back-to-back, then done.
        cfg(16'h0007, 2, 0, 0, 1'b1);
        run_idle(20);
        step();
        chk("tx3", int'(bus.tx_count), 3);

        // Stall two cycles on bit_idx 1 of 1,0,1.
        do_reset();
        cfg(16'h0005, 2, 0, 0, 1'b1);
        hold = 0;
        while (q.size() != 0 && hold < 40) begin
            bus.ready = !(q[0].kind == 0 && q[0].idx == 1 && hold < 2);
            if (!bus.ready) hold++;
            step();
        end
        bus.ready = 1'b1;
        if (q.size() != 0) chk("timeout", 1, 0);

        // Three 2-bit bursts with two-cycle gaps.
        cfg(16'h0003, 1, 2, 2, 1'b1);
        run_idle(40);

        // Abort mid-burst, then restart with the same settings.
        cfg(16'hA5C3, 7, 1, 1, 1'b1);
        hold = 0;
        while (!(q.size() != 0 && q[0].kind == 0 && q[0].idx == 5) && hold < 40) begin
            step();
            hold++;
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_idle(60);

        // Reset in a gap, then load+start while busy.
        cfg(16'hF0F0, 3, 2, 3, 1'b1);
        hold = 0;
        while (!(q.size() != 0 && q[0].kind == 1) && hold < 40) begin
            step();
            hold++;
        end
        do_reset();
        cfg(16'h00FF, 5, 0, 0, 1'b1);
        step();
        cfg(16'h1234, 9, 3, 4, 1'b1);
        run_idle(60);

        // 256 accepted bits wrap the counter.
        do_reset();
        cfg(16'hBEEF, 15, 15, 0, 1'b1);
        run_idle(400);
        @(negedge clk);
        chk("wrap", int'(bus.tx_count), 0);
        @(posedge clk); #1;

        // Random traffic.
        for (int c = 0; c < 6000; c++) begin
            rst         = ($urandom_range(0, 399) == 0);
            bus.pattern = 16'($urandom);
            bus.length  = 4'($urandom);
            bus.repeats = 4'($urandom_range(0, 3));
            bus.gap     = 4'($urandom_range(0, 3));
            bus.load    = ($urandom_range(0, 3) == 0);
            bus.start   = ($urandom_range(0, 3) == 0);
            bus.abort   = ($urandom_range(0, 59) == 0);
            bus.ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        rst       = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ready = 1'b1;
        run_idle(400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
